// File: rtl/path_arb.sv
// N-channel FIFO data path with a round-robin / fixed-priority burst arbiter
// driving a shared bus through a req_o/gnt_i handshake.
module path_arb #(
    parameter  int DATA_W    = 8,
    parameter  int NUM_CH    = 4,
    parameter  int DEPTH     = 4,
    parameter  int MAX_BURST = 4,
    localparam int CH_W      = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH*DATA_W-1:0] data_i,
    input  logic [NUM_CH-1:0]        valid_i,
    output logic [NUM_CH-1:0]        stop_o,
    output logic [NUM_CH-1:0]        ovf_o,
    input  logic                     mode_i,
    output logic                     req_o,
    input  logic                     gnt_i,
    output logic                     valid_o,
    output logic [DATA_W-1:0]        data_o,
    output logic [CH_W-1:0]          ch_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(MAX_BURST) + 1;

    typedef enum logic [1:0] {IDLE, REQ, XFER} state_t;

    state_t              state, state_next;
    logic [DATA_W-1:0]   mem [NUM_CH][DEPTH];
    logic [AW-1:0]       wr_ptr [NUM_CH];
    logic [AW-1:0]       rd_ptr [NUM_CH];
    logic [CW-1:0]       count [NUM_CH];
    logic [CW-1:0]       count_next [NUM_CH];
    logic [NUM_CH-1:0]   nonempty, nonempty_next, push, pop;
    logic [CH_W-1:0]     win, pick, rr_ptr;
    logic [BW-1:0]       burst_cnt;
    logic                pop_any, burst_last;
    int                  idx;

    always_comb begin
        nonempty = '0;
        for (int c = 0; c < NUM_CH; c++) nonempty[c] = (count[c] != '0);
        pop = '0;
        if (state == XFER && gnt_i && nonempty[win]) pop[win] = 1'b1;
        pop_any = |pop;
        nonempty_next = '0;
        stop_o = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            // A full FIFO still accepts a word when it is popped on the same edge.
            push[c]          = valid_i[c] && (count[c] != CW'(DEPTH) || pop[c]);
            count_next[c]    = count[c] + CW'(push[c]) - CW'(pop[c]);
            nonempty_next[c] = (count_next[c] != '0);
            stop_o[c]        = (count[c] >= CW'(DEPTH - 1));
        end
        burst_last = pop_any && (!nonempty_next[win] || burst_cnt == BW'(MAX_BURST - 1));
    end

    // Winner search: upward from rr_ptr in round-robin mode, from 0 in priority mode.
    always_comb begin
        pick = '0;
        idx  = 0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            idx = mode_i ? i : (int'(rr_ptr) + i) % NUM_CH;
            if (nonempty[idx]) pick = CH_W'(idx);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (|nonempty) state_next = REQ;
            REQ:     if (gnt_i) state_next = (|nonempty) ? XFER : IDLE;
            XFER:    if (burst_last) state_next = (|nonempty_next) ? REQ : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_o = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            win       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            valid_o   <= 1'b0;
            data_o    <= '0;
            ch_o      <= '0;
            ovf_o     <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                count[c]  <= '0;
            end
        end else begin
            valid_o <= pop_any;
            if (pop_any) begin
                data_o    <= mem[win][rd_ptr[win]];
                ch_o      <= win;
                burst_cnt <= burst_cnt + 1'b1;
            end
            if (state == REQ && gnt_i) begin
                win       <= pick;
                burst_cnt <= '0;
            end
            if (burst_last) rr_ptr <= (win == CH_W'(NUM_CH - 1)) ? '0 : win + 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                count[c] <= count_next[c];
                if (push[c]) wr_ptr[c] <= wr_ptr[c] + 1'b1;
                if (pop[c])  rd_ptr[c] <= rd_ptr[c] + 1'b1;
                if (valid_i[c] && !push[c]) ovf_o[c] <= 1'b1;
            end
        end
    end

    // NOTE: storage is not reset; counts and pointers alone define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++)
            if (push[c]) mem[c][wr_ptr[c]] <= data_i[c*DATA_W +: DATA_W];
    end
endmodule

// File: tb/tb_path_arb.sv
// Self-checking bench for path_arb: directed scenarios plus random traffic,
// compared every cycle against a queue-based transaction model.
module tb_path_arb;
    localparam int DATA_W    = 8;
    localparam int NUM_CH    = 4;
    localparam int DEPTH     = 4;
    localparam int MAX_BURST = 2;
    localparam int CH_W      = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic [NUM_CH*DATA_W-1:0] data_i;
    logic [NUM_CH-1:0]        valid_i, stop_o, ovf_o;
    logic                     mode_i, req_o, gnt_i, valid_o;
    logic [DATA_W-1:0]        data_o;
    logic [CH_W-1:0]          ch_o;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    path_arb #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .DEPTH(DEPTH), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .rst(rst), .data_i(data_i), .valid_i(valid_i), .stop_o(stop_o),
        .ovf_o(ovf_o), .mode_i(mode_i), .req_o(req_o), .gnt_i(gnt_i),
        .valid_o(valid_o), .data_o(data_o), .ch_o(ch_o)
    );

    // Reference model: one queue per channel, a bus owner (-1 while arbitrating).
    logic [DATA_W-1:0] mq [NUM_CH][$];
    bit                m_ovf [NUM_CH];
    bit                m_req, m_vout;
    int                m_owner = -1, m_taken, m_rr, m_chout;
    logic [DATA_W-1:0] m_dout;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        int  sz [NUM_CH];
        bit  any_before, any_after, popped;
        int  w;
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
            end
            m_req = 1'b0; m_owner = -1; m_rr = 0; m_vout = 1'b0; m_taken = 0;
            return;
        end
        any_before = 1'b0;
        for (int c = 0; c < NUM_CH; c++) begin
            sz[c] = mq[c].size();
            if (sz[c] > 0) any_before = 1'b1;
        end
        popped = 1'b0;
        if (m_owner >= 0 && gnt_i && sz[m_owner] > 0) begin
            m_dout  = mq[m_owner].pop_front();
            m_chout = m_owner;
            popped  = 1'b1;
            m_taken++;
        end
        for (int c = 0; c < NUM_CH; c++)
            if (valid_i[c]) begin
                if (mq[c].size() < DEPTH) mq[c].push_back(data_i[c*DATA_W +: DATA_W]);
                else m_ovf[c] = 1'b1;
            end
        m_vout = popped;
        any_after = 1'b0;
        for (int c = 0; c < NUM_CH; c++) if (mq[c].size() > 0) any_after = 1'b1;
        if (popped) begin
            if (mq[m_owner].size() == 0 || m_taken == MAX_BURST) begin
                m_rr    = (m_owner + 1) % NUM_CH;
                m_owner = -1;
                m_req   = any_after;
            end
        end else if (!m_req) begin
            m_req = any_before;
        end else if (m_owner < 0 && gnt_i) begin
            w = -1;
            for (int i = 0; i < NUM_CH; i++) begin
                int c;
                c = mode_i ? i : (m_rr + i) % NUM_CH;
                if (w < 0 && sz[c] > 0) w = c;
            end
            if (w < 0) m_req = 1'b0;
            m_owner = w;
            m_taken = 0;
        end
    endtask

    task automatic compare_outputs();
        logic [NUM_CH-1:0] exp_stop, exp_ovf;
        for (int c = 0; c < NUM_CH; c++) begin
            exp_stop[c] = (mq[c].size() >= DEPTH - 1);
            exp_ovf[c]  = m_ovf[c];
        end
        check("req_o", req_o, m_req);
        check("valid_o", valid_o, m_vout);
        if (m_vout) begin
            check("data_o", data_o, m_dout);
            check("ch_o", ch_o, m_chout);
        end
        check("stop_o", stop_o, exp_stop);
        check("ovf_o", ovf_o, exp_ovf);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        compare_outputs();
    endtask

    task automatic do_reset();
        rst = 1'b1; valid_i = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat, nvalid, sent0, sent3, seen;
        logic [DATA_W-1:0] log_d [$];
        int                log_c [$];

        rst = 1'b1; valid_i = '0; data_i = '0; gnt_i = 1'b0; mode_i = 1'b0;

        // Reset and idle: nothing requested, all outputs zero.
        tick(); tick();
        check("reset_data_o", data_o, 0);
        check("reset_ch_o", ch_o, 0);
        rst = 1'b0;
        repeat (5) tick();

        // Single word on channel 2 appears 3 cycles after its push edge.
        gnt_i = 1'b1;
        valid_i = 4'b0100; data_i[2*DATA_W +: DATA_W] = 8'hA5;
        tick();
        valid_i = '0;
        lat = 0; nvalid = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (valid_o) begin
                nvalid++;
                if (lat == 0) lat = k;
                check("single_data", data_o, 8'hA5);
                check("single_ch", ch_o, 2);
            end
        end
        check("single_latency", lat, 3);
        check("single_count", nvalid, 1);

        // Round-robin fairness with all four FIFOs pre-filled.
        do_reset();
        gnt_i = 1'b0; mode_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_i = '1;
            for (int c = 0; c < NUM_CH; c++) data_i[c*DATA_W +: DATA_W] = 8'(8'hC0 + c*4 + i);
            tick();
        end
        valid_i = '0; gnt_i = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (valid_o) begin log_d.push_back(data_o); log_c.push_back(int'(ch_o)); end
        end
        check("rr_words", log_d.size(), 16);
        for (int k = 0; k < log_d.size() && k < 16; k++) begin
            check("rr_order_ch", log_c[k], (k / 2) % NUM_CH);
            check("rr_order_data", log_d[k], 8'(8'hC0 + ((k / 2) % NUM_CH) * 4 + (k / 8) * 2 + k % 2));
        end

        // Fixed priority: channels 0 and 3 stream 30 words each, obeying stop_o.
        mode_i = 1'b1; gnt_i = 1'b1; sent0 = 0; sent3 = 0; nvalid = 0;
        for (int k = 0; k < 400; k++) begin
            valid_i = '0;
            if (sent0 < 30 && !stop_o[0] && $urandom_range(0, 3) != 0) begin
                valid_i[0] = 1'b1; data_i[0 +: DATA_W] = 8'(sent0); sent0++;
            end
            if (sent3 < 30 && !stop_o[3] && $urandom_range(0, 3) != 0) begin
                valid_i[3] = 1'b1; data_i[3*DATA_W +: DATA_W] = 8'(8'h80 + sent3); sent3++;
            end
            tick();
            if (valid_o) nvalid++;
        end
        valid_i = '0;
        check("prio_words", nvalid, 60);
        check("prio_ovf", ovf_o, 0);

        // Grant stall mid-burst, then overflow on channel 1.
        mode_i = 1'b0; gnt_i = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            valid_i = 4'b0011;
            data_i[0 +: DATA_W] = 8'(8'h10 + i);
            data_i[DATA_W +: DATA_W] = 8'(8'h20 + i);
            tick();
        end
        valid_i = '0; gnt_i = 1'b1; seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            tick();
            if (valid_o) seen = 1;
        end
        check("stall_first_word", seen, 1);
        gnt_i = 1'b0;
        repeat (5) tick();
        gnt_i = 1'b1;
        repeat (30) tick();
        gnt_i = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            valid_i = 4'b0010; data_i[DATA_W +: DATA_W] = 8'(8'h40 + i);
            tick();
        end
        valid_i = '0;
        check("ovf_ch1", ovf_o[1], 1'b1);
        gnt_i = 1'b1;
        repeat (20) tick();

        // Reset during a burst with words still queued.
        for (int i = 0; i < 3; i++) begin
            valid_i = '1;
            for (int c = 0; c < NUM_CH; c++) data_i[c*DATA_W +: DATA_W] = 8'($urandom);
            tick();
        end
        valid_i = '0; seen = 0;
        for (int k = 0; k < 10 && seen == 0; k++) begin
            tick();
            if (valid_o) seen = 1;
        end
        check("midburst_started", seen, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midburst_valid", valid_o, 1'b0);
        check("midburst_req", req_o, 1'b0);
        check("midburst_stop", stop_o, 0);
        repeat (10) tick();

        // Random traffic: occasional stop_o violations, grant gaps, mode flips, resets.
        for (int k = 0; k < 3000; k++) begin
            for (int c = 0; c < NUM_CH; c++) begin
                valid_i[c] = ($urandom_range(0, 2) == 0) && (!stop_o[c] || $urandom_range(0, 15) == 0);
                data_i[c*DATA_W +: DATA_W] = 8'($urandom);
            end
            gnt_i  = ($urandom_range(0, 3) != 0);
            mode_i = $urandom_range(0, 1) == 1;
            rst    = ($urandom_range(0, 499) == 0);
            tick();
        end
        rst = 1'b0; valid_i = '0; gnt_i = 1'b1;
        repeat (40) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
